// File: rtl/ehl_ahb_pkg.sv
// Shared encodings and data patterns for the AHB-Lite response-generator slave.
package ehl_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] RS_IDLE = 2'd0;
  localparam logic [1:0] RS_WAIT = 2'd1;
  localparam logic [1:0] RS_ERR1 = 2'd2;
  localparam logic [1:0] RS_ERR2 = 2'd3;

  localparam logic [31:0] ERR_PATTERN = 32'hDE00EE00;

  // Read-data signature of a completed OKAY transfer: marker, region, transfer sequence number.
  function automatic logic [31:0] okPattern(input logic [3:0] region, input logic [15:0] seq);
    return {8'hDE, 4'h0, region, seq};
  endfunction

endpackage

// File: rtl/ehl_ahb_resp_slave_if.sv
// AHB-Lite slave-side bus bundle for ehl_ahb_resp_slave.
interface ehl_ahb_resp_slave_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic          hready_in;
  logic          hready;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hready_in,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hready_in,
    output hready, hresp, hrdata
  );

endinterface

// File: rtl/ehl_ahb_resp_region_dec.sv
// Address-to-region decode: picks the region index and muxes out its wait count and error bit.
module ehl_ahb_resp_region_dec #(
  parameter int AW     = 32,
  parameter int NREG   = 4,
  parameter int RSHIFT = 12,
  parameter int DLY_W  = 8
) (
  input  logic [AW-1:0]         i_haddr,
  input  logic [NREG*DLY_W-1:0] i_resp_delay,
  input  logic [NREG-1:0]       i_resp_err,
  output logic [3:0]            o_region,
  output logic [DLY_W-1:0]      o_delay,
  output logic                  o_err
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [RW-1:0] w_idx;
  logic          w_unused;

  // A single-region build has no index bits, so everything lands in region 0.
  generate
    if (NREG > 1) begin : g_multi
      assign w_idx = i_haddr[RSHIFT +: RW];
    end else begin : g_single
      assign w_idx = '0;
    end
  endgenerate

  assign o_region = 4'(w_idx);
  assign o_delay  = i_resp_delay[w_idx*DLY_W +: DLY_W];
  assign o_err    = i_resp_err[w_idx];
  assign w_unused = ^i_haddr;

endmodule

// File: rtl/ehl_ahb_resp_slave.sv
// AHB-Lite response-generator slave with per-region wait states and OKAY/ERROR responses.
// Define EHL_AHB_RESP_SLAVE_ERRLOG_EN to build the first-error log and error counter.
module ehl_ahb_resp_slave
  import ehl_ahb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int NREG   = 4,
  parameter int RSHIFT = 12,
  parameter int DLY_W  = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ehl_ahb_resp_slave_if.slave   bus,
  input  logic [NREG*DLY_W-1:0] resp_delay,
  input  logic [NREG-1:0]       resp_err,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [AW-1:0]         err_addr,
  output logic                  err_write,
  output logic [7:0]            err_cnt
);

  logic [1:0]       r_state, w_stateNxt;
  logic [DLY_W-1:0] r_cnt, w_cntNxt;
  logic [15:0]      r_seq;
  logic [3:0]       r_region;
  logic             r_err;
  logic             r_hready, w_hreadyNxt;
  logic [1:0]       r_hresp, w_hrespNxt;
  logic [DW-1:0]    r_hrdata;
  logic [31:0]      w_wordNxt;
  logic             w_accept, w_take, w_err1Entry;
  logic [3:0]       w_region;
  logic [DLY_W-1:0] w_delay;
  logic             w_err;

  assign w_accept = bus.hsel & bus.hready_in & bus.htrans[1];

  ehl_ahb_resp_region_dec #(
    .AW     (AW),
    .NREG   (NREG),
    .RSHIFT (RSHIFT),
    .DLY_W  (DLY_W)
  ) u_dec (
    .i_haddr      (bus.haddr),
    .i_resp_delay (resp_delay),
    .i_resp_err   (resp_err),
    .o_region     (w_region),
    .o_delay      (w_delay),
    .o_err        (w_err)
  );

  // Next-state and next-output logic; ERR2 takes a new transfer exactly like IDLE does.
  always_comb begin
    w_stateNxt  = RS_IDLE;
    w_cntNxt    = r_cnt;
    w_hreadyNxt = 1'b1;
    w_hrespNxt  = HRESP_OKAY;
    w_wordNxt   = '0;
    w_take      = 1'b0;
    w_err1Entry = 1'b0;
    case (r_state)
      RS_WAIT: begin
        if (r_cnt <= DLY_W'(1)) begin
          if (r_err) begin
            w_stateNxt  = RS_ERR1;
            w_hreadyNxt = 1'b0;
            w_hrespNxt  = HRESP_ERROR;
            w_wordNxt   = ERR_PATTERN;
            w_err1Entry = 1'b1;
          end else begin
            w_wordNxt = okPattern(r_region, r_seq);
          end
        end else begin
          w_stateNxt  = RS_WAIT;
          w_cntNxt    = r_cnt - DLY_W'(1);
          w_hreadyNxt = 1'b0;
        end
      end
      RS_ERR1: begin
        w_stateNxt = RS_ERR2;
        w_hrespNxt = HRESP_ERROR;
        w_wordNxt  = ERR_PATTERN;
      end
      default: begin
        if (w_accept) begin
          w_take = 1'b1;
          if (w_delay != '0) begin
            w_stateNxt  = RS_WAIT;
            w_cntNxt    = w_delay;
            w_hreadyNxt = 1'b0;
          end else if (w_err) begin
            w_stateNxt  = RS_ERR1;
            w_hreadyNxt = 1'b0;
            w_hrespNxt  = HRESP_ERROR;
            w_wordNxt   = ERR_PATTERN;
            w_err1Entry = 1'b1;
          end else begin
            w_wordNxt = okPattern(w_region, r_seq + 16'd1);
          end
        end
      end
    endcase
  end

  // Region and error bit are latched on accept so config changes cannot disturb a data phase.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= RS_IDLE;
      r_cnt    <= '0;
      r_seq    <= '0;
      r_region <= '0;
      r_err    <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_hrdata <= '0;
    end else begin
      r_state  <= w_stateNxt;
      r_cnt    <= w_cntNxt;
      r_hready <= w_hreadyNxt;
      r_hresp  <= w_hrespNxt;
      r_hrdata <= {(DW/32){w_wordNxt}};
      if (w_take) begin
        r_seq    <= r_seq + 16'd1;
        r_region <= w_region;
        r_err    <= w_err;
      end
    end
  end

  assign bus.hready = r_hready;
  assign bus.hresp  = r_hresp;
  assign bus.hrdata = r_hrdata;

`ifdef EHL_AHB_RESP_SLAVE_ERRLOG_EN
  logic [AW-1:0] r_addr, r_errAddr, w_logAddr;
  logic          r_write, r_errWrite, r_errValid, w_logWrite;
  logic [7:0]    r_errCnt;
  logic          w_unused;

  // A waited error reports the address latched at accept; a zero-wait one reports the live bus.
  assign w_logAddr  = (r_state == RS_WAIT) ? r_addr  : bus.haddr;
  assign w_logWrite = (r_state == RS_WAIT) ? r_write : bus.hwrite;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_errAddr  <= '0;
      r_errWrite <= 1'b0;
      r_errValid <= 1'b0;
      r_errCnt   <= '0;
    end else begin
      if (w_take) begin
        r_addr  <= bus.haddr;
        r_write <= bus.hwrite;
      end
      if (w_err1Entry) begin
        if (!r_errValid || err_clr) begin
          r_errAddr  <= w_logAddr;
          r_errWrite <= w_logWrite;
        end
        r_errValid <= 1'b1;
        if (err_clr) begin
          r_errCnt <= 8'd1;
        end else if (r_errCnt != 8'hFF) begin
          r_errCnt <= r_errCnt + 8'd1;
        end
      end else if (err_clr) begin
        r_errValid <= 1'b0;
        r_errCnt   <= '0;
      end
    end
  end

  assign err_valid = r_errValid;
  assign err_addr  = r_errAddr;
  assign err_write = r_errWrite;
  assign err_cnt   = r_errCnt;
  assign w_unused  = bus.htrans[0];
`else
  logic w_unused;

  assign err_valid = 1'b0;
  assign err_addr  = '0;
  assign err_write = 1'b0;
  assign err_cnt   = '0;
  assign w_unused  = ^{err_clr, bus.hwrite, bus.htrans[0], bus.haddr, w_err1Entry};
`endif

endmodule
